config_read_fifo: RTL and testbench

Buffers read responses from the `Config` bus and presents them to a downstream consumer over a valid/ready stream. The block taps the bus next to the Slave: it watches `r_en`/`w_en` and samples `read_data` once the Slave has updated it. It sits directly downstream of the Slave, so a consumer can drain responses at its own pace without stalling the Master's fixed request cadence. Overflow is flagged rather than back-pressured, because the bus has no stall mechanism.

---
 rtl/config_read_fifo_if.sv | 31 +++
 rtl/config_read_fifo.sv | 126 ++++++++++++
 tb/tb_config_read_fifo.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/config_read_fifo_if.sv
// Bus-tap and response-stream signals for config_read_fifo.
// The slave modport is the FIFO's view: it watches the Config bus and
// drives the stream. The master modport is the bus/consumer side.
interface config_read_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  bus_r_en;
    logic                  bus_w_en;
    logic [DATA_WIDTH-1:0] bus_read_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  bus_r_en,
        input  bus_w_en,
        input  bus_read_data,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output bus_r_en,
        output bus_w_en,
        output bus_read_data,
        output out_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/config_read_fifo.sv
// Captures Config-bus read responses into a small circular FIFO and
// presents them on a valid/ready stream. The bus cannot be stalled, so a
// response arriving while the FIFO is full (and nothing is popped) is
// dropped and reported through the sticky overflow flag.
module config_read_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    config_read_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Registered state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  r_cap_pend;

    // Combinational next-state and control
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_write;
    logic                  w_drop;
    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_valid_nxt;
    logic                  w_overflow_nxt;
    logic                  w_cap_pend_nxt;

    // Push/pop decisions: a full FIFO still accepts a push when it is popped in the same cycle
    always_comb begin
        w_push  = r_cap_pend;
        w_pop   = r_valid & bus.out_ready;
        w_full  = (r_count == FULL_CNT);
        w_write = w_push & (~w_full | w_pop);
        w_drop  = w_push & w_full & ~w_pop;
    end

    // Next-state for pointers, occupancy, flags and capture; clear overrides everything
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        // r_en wins over w_en on the bus, so only a pure write cycle yields fresh read_data
        w_cap_pend_nxt = bus.bus_w_en & ~bus.bus_r_en;

        if (clear) begin
            w_wr_ptr_nxt   = {PW{1'b0}};
            w_rd_ptr_nxt   = {PW{1'b0}};
            w_count_nxt    = {CW{1'b0}};
            w_overflow_nxt = 1'b0;
            w_cap_pend_nxt = 1'b0;
        end else begin
            if (w_write) begin
                w_wr_ptr_nxt = r_wr_ptr + PW'(1);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end

            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PW'(1);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end

            case ({w_write, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase

            if (w_drop) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_overflow_nxt = r_overflow;
            end
        end

        w_valid_nxt = (w_count_nxt != {CW{1'b0}});
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_cap_pend <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_valid    <= w_valid_nxt;
            r_overflow <= w_overflow_nxt;
            r_cap_pend <= w_cap_pend_nxt;
        end
    end

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (w_write & ~clear) begin
            r_mem[r_wr_ptr] <= bus.bus_read_data;
        end
    end

    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_valid = r_valid;
    assign count         = r_count;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_config_read_fifo.sv
// Self-checking bench for config_read_fifo: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_config_read_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [3-1:0] count;
    logic         overflow;

    config_read_fifo_if #(.DATA_WIDTH(DW)) bus_if ();

    config_read_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .bus      (bus_if.slave),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act == exp) passed = passed + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_q[$];
    bit            m_ovf;
    bit            m_pend;
    int            m_sz;
    bit            m_pop;
    logic [DW-1:0] m_dummy;

    // Model update: responses are captured one cycle after a pure write cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_pend = 1'b0;
        end else if (clear) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_sz  = m_q.size();
            m_pop = (m_sz != 0) && bus_if.out_ready;
            if (m_pop) m_dummy = m_q.pop_front();
            if (m_pend) begin
                if (m_sz < DEPTH || m_pop) m_q.push_back(bus_if.bus_read_data);
                else m_ovf = 1'b1;
            end
            m_pend = bus_if.bus_w_en && !bus_if.bus_r_en;
        end
    end

    logic [DW-1:0] dut_log[$];

    // Per-cycle comparison against the model, plus a log of popped data
    always @(negedge clk) begin
        chk("count", int'(count), m_q.size());
        chk("out_valid", int'(bus_if.out_valid), int'(m_q.size() != 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (m_q.size() != 0) chk("out_data", int'(bus_if.out_data), int'(m_q[0]));
        if (bus_if.out_valid && bus_if.out_ready) dut_log.push_back(bus_if.out_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic inject(input logic [DW-1:0] d);
        bus_if.bus_w_en = 1'b1;
        bus_if.bus_r_en = 1'b0;
        step();
        bus_if.bus_w_en      = 1'b0;
        bus_if.bus_read_data = d;
        step();
    endtask

    task automatic chk_log(input string name, input logic [DW-1:0] exp[$]);
        chk({name, "_len"}, dut_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
            chk(name, int'(dut_log[i]), int'(exp[i]));
    endtask

    logic [DW-1:0] exp_q[$];
    int            maxc;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n                = 1'b0;
        clear                = 1'b0;
        bus_if.bus_r_en      = 1'b0;
        bus_if.bus_w_en      = 1'b0;
        bus_if.bus_read_data = 8'h00;
        bus_if.out_ready     = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(bus_if.out_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", int'(bus_if.out_valid), 0);

        // Single response, consumer always ready
        bus_if.out_ready = 1'b1;
        bus_if.bus_w_en  = 1'b1;
        step();
        bus_if.bus_w_en      = 1'b0;
        bus_if.bus_read_data = 8'h5A;
        step();
        #1;
        chk("single_valid", int'(bus_if.out_valid), 1);
        chk("single_data", int'(bus_if.out_data), 8'h5A);
        step();
        chk("single_count0", int'(count), 0);

        // r_en wins over w_en: no capture
        bus_if.bus_r_en = 1'b1;
        bus_if.bus_w_en = 1'b1;
        bus_if.bus_read_data = 8'hEE;
        step();
        bus_if.bus_r_en = 1'b0;
        bus_if.bus_w_en = 1'b0;
        step(); step();
        chk("prio_count", int'(count), 0);
        chk("prio_valid", int'(bus_if.out_valid), 0);

        // Fill then overflow, drain in order
        bus_if.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) inject(8'(i));
        chk("fill_count", int'(count), 4);
        chk("fill_ovf", int'(overflow), 1);
        dut_log.delete();
        bus_if.out_ready = 1'b1;
        repeat (6) step();
        bus_if.out_ready = 1'b0;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk_log("drain_ovf", exp_q);
        chk("ovf_sticky", int'(overflow), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_ovf", int'(overflow), 0);

        // Full plus simultaneous push/pop
        for (int i = 0; i < 4; i++) inject(8'h10 + 8'(i));
        chk("full_count", int'(count), 4);
        dut_log.delete();
        bus_if.bus_w_en = 1'b1;
        step();
        bus_if.bus_w_en      = 1'b0;
        bus_if.bus_read_data = 8'h14;
        bus_if.out_ready     = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        chk("pp_count", int'(count), 4);
        chk("pp_ovf", int'(overflow), 0);
        bus_if.out_ready = 1'b1;
        repeat (6) step();
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        chk_log("drain_pp", exp_q);

        // Wrap-around streaming
        dut_log.delete();
        maxc = 0;
        for (int i = 0; i < 10; i++) begin
            bus_if.bus_w_en      = 1'b1;
            bus_if.bus_read_data = (i == 0) ? 8'h00 : 8'hA0 + 8'(i - 1);
            step();
            if (int'(count) > maxc) maxc = int'(count);
        end
        bus_if.bus_w_en      = 1'b0;
        bus_if.bus_read_data = 8'hA9;
        repeat (4) begin
            step();
            if (int'(count) > maxc) maxc = int'(count);
        end
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        chk_log("wrap", exp_q);
        chk("wrap_maxcnt_le1", int'(maxc <= 1), 1);
        chk("wrap_ovf", int'(overflow), 0);

        // Clear with count 3 and overflow set
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) inject(8'h30 + 8'(i));
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        chk("pre_clear_count", int'(count), 3);
        chk("pre_clear_ovf", int'(overflow), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_count", int'(count), 0);
        chk("clear_ovf2", int'(overflow), 0);
        chk("clear_valid", int'(bus_if.out_valid), 0);

        // Response pending while clear is asserted is lost
        bus_if.bus_w_en = 1'b1;
        step();
        bus_if.bus_w_en      = 1'b0;
        bus_if.bus_read_data = 8'h77;
        clear                = 1'b1;
        step();
        clear = 1'b0;
        step();
        chk("clear_pend_count", int'(count), 0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) inject(8'h40 + 8'(i));
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        chk("pre_rst_count", int'(count), 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_valid", int'(bus_if.out_valid), 0);
        chk("async_rst_ovf", int'(overflow), 0);
        #3;
        rst_n = 1'b1;
        step();
        chk("after_rst_valid", int'(bus_if.out_valid), 0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
